// File: rtl/imem_loader_pkg.sv
// Shared types and sizing for the boot-time instruction-memory loader.
package imem_loader_pkg;
  localparam int XLEN             = 32;
  localparam int ADDR_WIDTH       = 9;
  localparam int MEM_SIZE         = 2**ADDR_WIDTH;
  localparam int LOADER_LEN_WIDTH = 16;

  typedef logic [XLEN-1:0] word_t;

  typedef logic [2:0] loader_state_e;
  localparam loader_state_e ST_IDLE    = 3'd0;
  localparam loader_state_e ST_HDR_LO  = 3'd1;
  localparam loader_state_e ST_HDR_HI  = 3'd2;
  localparam loader_state_e ST_PAYLOAD = 3'd3;
  localparam loader_state_e ST_CHECK   = 3'd4;
  localparam loader_state_e ST_DONE    = 3'd5;
  localparam loader_state_e ST_ERROR   = 3'd6;

  // States in which the loader owns the byte stream.
  function automatic logic state_busy(input loader_state_e s);
    return s inside {ST_HDR_LO, ST_HDR_HI, ST_PAYLOAD, ST_CHECK};
  endfunction
endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port.
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  word_t                 mem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader_byte_word_packer.sv
// Packs accepted bytes little-endian into words; flags the 4th byte of each word.
module byte_word_packer
  import imem_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       byte_en,
  input  logic [7:0] byte_data,
  output logic       word_valid,
  output word_t      word
);
  logic [1:0]  lane;
  logic [23:0] shreg;

  // Earlier bytes shift down so the first byte lands in bits 7:0.
  assign word_valid = byte_en && (lane == 2'd3);
  assign word       = {byte_data, shreg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane  <= '0;
      shreg <= '0;
    end else if (clr) begin
      lane  <= '0;
    end else if (byte_en) begin
      lane  <= lane + 2'd1;
      shreg <= {byte_data, shreg[23:8]};
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, checksummed byte stream into instruction memory
// and releases the core from reset only after a clean load.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  imem_loader_if.slave bus,
  output logic       core_rst_n,
  output logic       busy,
  output logic       done,
  output logic       err
);
  localparam int MEM_WORDS = 2**ADDR_WIDTH;
  localparam int CW        = ADDR_WIDTH + 1;
  localparam int LW        = LOADER_LEN_WIDTH;

  loader_state_e   state;
  logic [LW-1:0]   len;
  logic [CW-1:0]   word_cnt;
  logic [7:0]      csum;
  logic            accept;
  logic            launch;
  logic            word_valid;
  logic [XLEN-1:0] word;
  logic [LW-1:0]   hdr;

  assign busy           = state_busy(state);
  assign bus.byte_ready = busy;
  assign accept         = bus.byte_valid && busy;
  assign launch         = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
  assign hdr            = {bus.byte_data, len[7:0]};

  byte_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (launch),
    .byte_en    (accept && (state == ST_PAYLOAD)),
    .byte_data  (bus.byte_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      len           <= '0;
      word_cnt      <= '0;
      csum          <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
      core_rst_n    <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      if (launch) begin
        state      <= ST_HDR_LO;
        word_cnt   <= '0;
        csum       <= '0;
        done       <= 1'b0;
        err        <= 1'b0;
        core_rst_n <= 1'b0;
      end else if (accept) begin
        case (state)
          ST_HDR_LO: begin
            len[7:0] <= bus.byte_data;
            state    <= ST_HDR_HI;
          end
          ST_HDR_HI: begin
            // Full 16-bit compare: N == MEM_WORDS is the largest legal load.
            if (hdr == '0 || hdr > LW'(MEM_WORDS)) begin
              state <= ST_ERROR;
              err   <= 1'b1;
            end else begin
              len   <= hdr;
              state <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            csum <= csum + bus.byte_data;
            if (word_valid) begin
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= word_cnt[ADDR_WIDTH-1:0];
              bus.mem_wdata <= word;
              word_cnt      <= word_cnt + CW'(1);
              if (LW'(word_cnt) + LW'(1) == len)
                state <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (bus.byte_data == csum) begin
              state      <= ST_DONE;
              done       <= 1'b1;
              core_rst_n <= 1'b1;
            end else begin
              state <= ST_ERROR;
              err   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed, table-driven bench for imem_loader.
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic core_rst_n, busy, done, err;

  imem_loader_if bus();

  imem_loader #(.XLEN(32), .ADDR_WIDTH(9)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bus        (bus),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_count = 0;
  logic [31:0] pay [0:511];

  always @(negedge clk)
    if (rst_n && bus.mem_we) wr_count <= wr_count + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int cnt;
    bus.byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    cnt = 0;
    while (!bus.byte_ready && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (!bus.byte_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_byte timeout: byte_ready stuck low for byte %h", b);
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic int gap_of(input int max_gap);
    return (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
  endfunction

  task automatic run_load(input logic [15:0] n, input logic [7:0] flip, input int max_gap,
                          input bit hdr_bad, input bit exp_ok, input bit start_mid);
    int wr0;
    logic [7:0] sum;
    logic [7:0] b;
    wr0 = wr_count;
    pulse_start();
    check("busy after start", 32'(busy), 32'd1);
    check("done cleared", 32'(done), 32'd0);
    send_byte(n[7:0], gap_of(max_gap));
    send_byte(n[15:8], gap_of(max_gap));
    if (hdr_bad) begin
      check("hdr err", 32'(err), 32'd1);
      check("hdr done", 32'(done), 32'd0);
      check("hdr core_rst_n", 32'(core_rst_n), 32'd0);
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'h55;
      for (int i = 0; i < 4; i++) begin
        check("hdr byte_ready low", 32'(bus.byte_ready), 32'd0);
        @(negedge clk);
      end
      bus.byte_valid = 1'b0;
      check("hdr no writes", 32'(wr_count - wr0), 32'd0);
      return;
    end
    sum = 8'h00;
    for (int w = 0; w < int'(n); w++) begin
      for (int k = 0; k < 4; k++) begin
        b = pay[w][8*k +: 8];
        sum = sum + b;
        send_byte(b, gap_of(max_gap));
      end
      check("mem_we", 32'(bus.mem_we), 32'd1);
      check("mem_addr", 32'(bus.mem_addr), 32'(w));
      check("mem_wdata", bus.mem_wdata, pay[w]);
      if (start_mid && w == 100) begin
        pulse_start();
        check("busy after ignored start", 32'(busy), 32'd1);
      end
    end
    send_byte(sum ^ flip, gap_of(max_gap));
    check("result done", 32'(done), 32'(exp_ok));
    check("result err", 32'(err), 32'(!exp_ok));
    check("result core_rst_n", 32'(core_rst_n), 32'(exp_ok));
    check("result busy", 32'(busy), 32'd0);
    check("result ready", 32'(bus.byte_ready), 32'd0);
    check("write count", 32'(wr_count - wr0), 32'(n));
  endtask

  typedef struct {
    logic [15:0] n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  flip;
    int          max_gap;
    bit          hdr_bad;
    bit          exp_ok;
  } vec_t;

  vec_t vt [6];

  initial begin
    vt[0] = '{16'd2,   32'h00500093, 32'h00100113, 8'h00, 0, 1'b0, 1'b1};
    vt[1] = '{16'd2,   32'h00500093, 32'h00100113, 8'h0F, 0, 1'b0, 1'b0}; // checksum 0x08
    vt[2] = '{16'd2,   32'h00500093, 32'h00100113, 8'h00, 0, 1'b0, 1'b1};
    vt[3] = '{16'd0,   32'h0,        32'h0,        8'h00, 0, 1'b1, 1'b0};
    vt[4] = '{16'd513, 32'h0,        32'h0,        8'h00, 0, 1'b1, 1'b0};
    vt[5] = '{16'd2,   32'h00500093, 32'h00100113, 8'h00, 5, 1'b0, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst byte_ready", 32'(bus.byte_ready), 32'd0);
    check("rst mem_we", 32'(bus.mem_we), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst core_rst_n", 32'(core_rst_n), 32'd0);
    check("rst mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst mem_wdata", bus.mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 6; t++) begin
      if (vt[t].max_gap > 0) begin
        // Source offers bytes while idle; none may be taken.
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hAA;
        for (int i = 0; i < 5; i++) begin
          check("idle byte_ready", 32'(bus.byte_ready), 32'd0);
          @(negedge clk);
        end
        bus.byte_valid = 1'b0;
      end
      pay[0] = vt[t].w0;
      pay[1] = vt[t].w1;
      run_load(vt[t].n, vt[t].flip, vt[t].max_gap, vt[t].hdr_bad, vt[t].exp_ok, 1'b0);
    end

    // Async reset partway through a 3-word load.
    pay[0] = 32'h11223344;
    pay[1] = 32'h55667788;
    pay[2] = 32'h99AABBCC;
    pulse_start();
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    for (int k = 0; k < 5; k++) send_byte(pay[k/4][8*(k%4) +: 8], 0);
    check("mid mem_wdata before reset", bus.mem_wdata, 32'h11223344);
    #2 rst_n = 1'b0;
    #1;
    check("async byte_ready", 32'(bus.byte_ready), 32'd0);
    check("async busy", 32'(busy), 32'd0);
    check("async mem_we", 32'(bus.mem_we), 32'd0);
    check("async mem_addr", 32'(bus.mem_addr), 32'd0);
    check("async mem_wdata", bus.mem_wdata, 32'd0);
    check("async core_rst_n", 32'(core_rst_n), 32'd0);
    check("async done", 32'(done), 32'd0);
    check("async err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pay[0] = 32'h00500093;
    pay[1] = 32'h00100113;
    run_load(16'd2, 8'h00, 0, 1'b0, 1'b1, 1'b0);

    // Full-capacity load with an ignored start in the middle.
    for (int i = 0; i < 512; i++) pay[i] = 32'(i);
    run_load(16'd512, 8'h00, 0, 1'b0, 1'b1, 1'b1);
    check("last addr", 32'(bus.mem_addr), 32'd511);
    check("last wdata", bus.mem_wdata, 32'h000001FF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
